qc_ldpc_parity_encoder: RTL
===========================

Name: qc_ldpc_parity_encoder

Overview:
- Parametrised quasi-cyclic LDPC parity encoder. It is the successor to the fixed 360×12 encoder.
- It accumulates circulant generator rows from an external synchronous ROM for each set information bit, then streams the Z parity bits out serially.
- Adds over the previous generation:
  - valid/ready handshakes on both the input and output streams;
  - frame start and last markers;
  - an optional dual-diagonal (differential) accumulation mode on output.
- Sits between the bit-serial info scrambler and the frame mapper in the TX chain.

Parameters:
Z, 360, circulant size; parity bits per frame; width of a ROM row.
NG, 12, number of info groups; frame carries Z*NG info bits.
AW, 4, ROM address width; must satisfy 2^AW >= NG.
CW, 9, bit counter width; must satisfy 2^CW >= Z.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
start  in  1  one-cycle pulse; begins a frame when in IDLE.
diff_mode  in  1  sampled on accepted start; 0 = plain parity, 1 = dual-diagonal accumulate on output.
din_valid  in  1  info bit valid.
din_ready  out  1  encoder can accept an info bit.
din  in  1  info bit; transfers when din_valid && din_ready.
rom_addr  out  AW  generator row index; registered.
rom_data  in  Z  row data; valid 1 cycle after rom_addr is sampled, so 2 edges after rom_addr changes.
dout  out  1  parity bit.
dout_valid  out  1  parity bit valid.
dout_ready  in  1  downstream accepts; transfers when dout_valid && dout_ready.
dout_last  out  1  high with the final (Z-th) parity bit.
busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (asynchronous, rst_n low), every output 0:
  - state=IDLE; sum, row_reg, group g and bit counter k cleared.
  - din_ready=0, dout=0, dout_valid=0, dout_last=0, busy=0, rom_addr=0.
- FSM states: IDLE, FETCH, ACCUM, OUT.
- IDLE:
  - start=1 → clear sum, g=0, latch diff_mode, rom_addr=0, go to FETCH.
  - start in any other state is ignored.
- FETCH:
  - Lasts exactly 2 cycles with din_ready=0.
  - On the 2nd cycle, row_reg <= rom_data, k=0, go to ACCUM.
- ACCUM (din_ready=1):
  - On each transfer: if din=1, sum <= sum ^ row_reg.
  - Then row_reg <= {row_reg[0], row_reg[Z-1:1]} (rotate right 1), whatever din is. Bit k of group g therefore uses row g rotated right by k.
  - din_valid=0 → no state change; gaps are allowed.
  - Transfer with k==Z-1:
    - g<NG-1 → g++, rom_addr<=g+1, go to FETCH; din_ready drops the next cycle.
    - g==NG-1 → go to OUT, j=0.
- OUT (din_ready=0):
  - Emission j (0..Z-1) presents plain value s_j = sum[Z-1-j] (MSB first).
  - diff_mode=0: dout = s_j.
  - diff_mode=1: dout = s_j ^ dout_{j-1}, with dout_{-1}=0. Held in a 1-bit accumulator that updates only on a transfer.
  - dout, dout_valid and dout_last are registered. dout_valid rises the cycle after entering OUT.
  - While dout_valid && !dout_ready, dout and dout_last hold stable.
  - dout_last=1 exactly for j=Z-1. Its transfer → IDLE; dout_valid=0 the next cycle.
- Latency and throughput:
  - Minimum cycles from start to the first input transfer = 3 (1 to IDLE→FETCH, 2 in FETCH).
  - Minimum input phase = NG*(Z+2) cycles.
  - Output = Z cycles with dout_ready held high.
- Boundary conditions:
  - start coincident with dout_last transfer → ignored; the next start must come in IDLE.
  - Reset mid-frame aborts immediately. There is no partial output, and the next frame starts clean.
  - diff_mode changes mid-frame have no effect.
  - rom_data is sampled only on the 2nd FETCH cycle.

Test Plan:
- Reset value check: Z=8, NG=2, rst_n low mid-ACCUM → all outputs 0 asynchronously. After release, busy=0 and din_ready=0 until start.
- Rotation check: ROM{0:8'h01, 1:8'h80}, diff_mode=0, info bits 0,1,0..0 in group 0 and zeros in group 1 → sum=8'h80. dout sequence 1,0,0,0,0,0,0,0; dout_last on the 8th bit.
- Differential mode: same ROM, bit0 of group 0 = 1 and bit0 of group 1 = 1, rest 0 → sum=8'h81.
  - diff_mode=0 → 1,0,0,0,0,0,0,1.
  - diff_mode=1 → 1,1,1,1,1,1,1,0.
- Backpressure and gaps:
  - Random din_valid gaps and random dout_ready stalls produce output identical to the no-stall run.
  - dout stays stable during stalls.
  - din_ready=0 for exactly 2 cycles at each group boundary.
- Full-size default (Z=360, NG=12): all-ones info frame against the golden model; all-zero frame gives 360 zero bits. Check total input-phase cycles = 12*362 with din_valid high.
- Start while busy: start pulse in ACCUM and in OUT → no restart, and the frame completes with correct parity.

Source files
------------

// File: rtl/qc_ldpc_parity_encoder_if.sv
// Handshake and ROM bus bundle for the QC-LDPC parity encoder.
// The encoder takes the slave side; the feeding logic and ROM take the master side.
interface qc_ldpc_parity_encoder_if #(
    parameter int Z  = 360,
    parameter int AW = 4
);
    logic          start;
    logic          diff_mode;
    logic          din_valid;
    logic          din_ready;
    logic          din;
    logic [AW-1:0] rom_addr;
    logic [Z-1:0]  rom_data;
    logic          dout;
    logic          dout_valid;
    logic          dout_ready;
    logic          dout_last;
    logic          busy;

    modport master (
        output start, diff_mode, din_valid, din, rom_data, dout_ready,
        input  din_ready, rom_addr, dout, dout_valid, dout_last, busy
    );

    modport slave (
        input  start, diff_mode, din_valid, din, rom_data, dout_ready,
        output din_ready, rom_addr, dout, dout_valid, dout_last, busy
    );
endinterface

// File: rtl/qc_ldpc_parity_encoder.sv
// Quasi-cyclic LDPC parity encoder: XOR-accumulates rotated circulant rows for each set
// info bit, then streams the Z parity bits MSB first, optionally as a running XOR.
module qc_ldpc_parity_encoder #(
    parameter int Z  = 360,
    parameter int NG = 12,
    parameter int AW = 4,
    parameter int CW = 9
) (
    input  logic                   clk,
    input  logic                   rst_n,
    qc_ldpc_parity_encoder_if.slave bus
);
    typedef enum logic [1:0] {IDLE, FETCH, ACCUM, OUT} state_e;

    state_e        state_q, state_d;
    logic [Z-1:0]  sum_q, sum_d;
    logic [Z-1:0]  row_q, row_d;
    logic [AW-1:0] g_q, g_d;
    logic [AW-1:0] rom_addr_q, rom_addr_d;
    logic [CW-1:0] k_q, k_d;
    logic          fetch2_q, fetch2_d;
    logic          diff_q, diff_d;
    logic          din_ready_q, din_ready_d;
    logic          dout_q, dout_d;
    logic          dout_valid_q, dout_valid_d;
    logic          dout_last_q, dout_last_d;
    logic          busy_q, busy_d;
    logic          din_xfer, dout_xfer, k_last;

    assign din_xfer  = bus.din_valid & din_ready_q;
    assign dout_xfer = dout_valid_q & bus.dout_ready;
    assign k_last    = (k_q == CW'(Z - 1));

    always_comb begin
        state_d      = state_q;
        sum_d        = sum_q;
        row_d        = row_q;
        g_d          = g_q;
        rom_addr_d   = rom_addr_q;
        k_d          = k_q;
        fetch2_d     = fetch2_q;
        diff_d       = diff_q;
        din_ready_d  = din_ready_q;
        dout_d       = dout_q;
        dout_valid_d = dout_valid_q;
        dout_last_d  = dout_last_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    sum_d      = '0;
                    g_d        = '0;
                    diff_d     = bus.diff_mode;
                    rom_addr_d = '0;
                    fetch2_d   = 1'b0;
                    state_d    = FETCH;
                end
            end
            FETCH: begin
                // ROM output only reflects rom_addr two edges after it moved
                if (!fetch2_q) begin
                    fetch2_d = 1'b1;
                end else begin
                    fetch2_d    = 1'b0;
                    row_d       = bus.rom_data;
                    k_d         = '0;
                    din_ready_d = 1'b1;
                    state_d     = ACCUM;
                end
            end
            ACCUM: begin
                if (din_xfer) begin
                    if (bus.din) sum_d = sum_q ^ row_q;
                    row_d = {row_q[0], row_q[Z-1:1]};
                    if (k_last) begin
                        din_ready_d = 1'b0;
                        k_d         = '0;
                        if (g_q == AW'(NG - 1)) begin
                            state_d = OUT;
                        end else begin
                            g_d        = g_q + 1'b1;
                            rom_addr_d = g_q + 1'b1;
                            state_d    = FETCH;
                        end
                    end else begin
                        k_d = k_q + 1'b1;
                    end
                end
            end
            OUT: begin
                // sum shifts left per emission so the next plain bit is always near the MSB;
                // dout_q doubles as the differential accumulator
                if (!dout_valid_q) begin
                    dout_d       = sum_q[Z-1];
                    dout_valid_d = 1'b1;
                    dout_last_d  = (Z == 1);
                end else if (dout_xfer) begin
                    if (dout_last_q) begin
                        dout_d       = 1'b0;
                        dout_valid_d = 1'b0;
                        dout_last_d  = 1'b0;
                        state_d      = IDLE;
                    end else begin
                        sum_d       = sum_q << 1;
                        k_d         = k_q + 1'b1;
                        dout_d      = sum_q[Z-2] ^ (diff_q & dout_q);
                        dout_last_d = (k_q == CW'(Z - 2));
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            sum_q        <= '0;
            row_q        <= '0;
            g_q          <= '0;
            rom_addr_q   <= '0;
            k_q          <= '0;
            fetch2_q     <= 1'b0;
            diff_q       <= 1'b0;
            din_ready_q  <= 1'b0;
            dout_q       <= 1'b0;
            dout_valid_q <= 1'b0;
            dout_last_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            sum_q        <= sum_d;
            row_q        <= row_d;
            g_q          <= g_d;
            rom_addr_q   <= rom_addr_d;
            k_q          <= k_d;
            fetch2_q     <= fetch2_d;
            diff_q       <= diff_d;
            din_ready_q  <= din_ready_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            dout_last_q  <= dout_last_d;
            busy_q       <= busy_d;
        end
    end

    assign bus.din_ready  = din_ready_q;
    assign bus.rom_addr   = rom_addr_q;
    assign bus.dout       = dout_q;
    assign bus.dout_valid = dout_valid_q;
    assign bus.dout_last  = dout_last_q;
    assign bus.busy       = busy_q;
endmodule
